// File: rtl/tge_tx_scheduler.sv
`timescale 1ns/1ps
// tge_tx_scheduler: test-packet generator and transmit sequencer for the
// gbe0 10GbE core, with status counters for the software registers.
//
// Ports:
//   user_clk, user_rst        clock, synchronous active-high reset
//   enable                    run/stop
//   pkt_len                   words per packet (0 treated as 1), sampled at start
//   period                    cycles between packet start ticks (0 treated as 1)
//   tx_afull                  almost-full backpressure from the core
//   tx_valid, tx_data,
//   tx_end_of_frame           registered transmit word to the core
//   txfull_ctr                rising edges of tx_afull (saturating)
//   pkt_ctr                   packets completed (wrapping)
//   skip_ctr                  ticks dropped while one was pending (saturating)
//   wdog_flag                 sticky stall-timeout flag
//
// Optional feature: define TGE_TX_SCHED_WDOG_EN to enable the stall
// watchdog (WDOG_CYCLES). Without it, STALL waits forever and wdog_flag is 0.

module tge_tx_scheduler #(
    parameter int unsigned CTR_WIDTH   = 32,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                 user_clk,
    input  logic                 user_rst,
    input  logic                 enable,
    input  logic [LEN_WIDTH-1:0] pkt_len,
    input  logic [31:0]          period,
    input  logic                 tx_afull,
    output logic                 tx_valid,
    output logic [63:0]          tx_data,
    output logic                 tx_end_of_frame,
    output logic [CTR_WIDTH-1:0] txfull_ctr,
    output logic [CTR_WIDTH-1:0] pkt_ctr,
    output logic [CTR_WIDTH-1:0] skip_ctr,
    output logic                 wdog_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          period_cnt_q, period_cnt_d;
    logic                 pending_q, pending_d;
    logic                 afull_q;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [31:0]          seq_q, seq_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [63:0]          tx_data_q, tx_data_d;
    logic                 tx_eof_q, tx_eof_d;
    logic [CTR_WIDTH-1:0] txfull_q, txfull_d;
    logic [CTR_WIDTH-1:0] pkt_q, pkt_d;
    logic [CTR_WIDTH-1:0] skip_q, skip_d;

    logic tick;
    logic start;
    logic last_word;
    logic abort_w;

`ifdef TGE_TX_SCHED_WDOG_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        abort_q, abort_d;
    logic        wdog_q, wdog_d;

    assign abort_w   = abort_q;
    assign wdog_flag = wdog_q;
`else
    localparam int unsigned wdog_cycles_unused = WDOG_CYCLES;

    assign abort_w   = 1'b0;
    assign wdog_flag = 1'b0;
`endif

    // Period counter, pending tick and status counters
    always_comb begin
        tick  = enable && (period_cnt_q == '0);
        start = (state_q == IDLE) && pending_q && enable && !afull_q;

        period_cnt_d = period_cnt_q;
        if (!enable) begin
            period_cnt_d = '0;
        end else if (tick) begin
            period_cnt_d = (period == 32'd0) ? 32'd0 : period - 32'd1;
        end else begin
            period_cnt_d = period_cnt_q - 32'd1;
        end

        // A new tick wins over consumption, so tick+start keeps pending set
        pending_d = pending_q;
        if (!enable) begin
            pending_d = 1'b0;
        end else if (tick) begin
            pending_d = 1'b1;
        end else if (start) begin
            pending_d = 1'b0;
        end

        skip_d = skip_q;
        if (tick && pending_q && !start && !(&skip_q)) begin
            skip_d = skip_q + CTR_WIDTH'(1);
        end

        txfull_d = txfull_q;
        if (tx_afull && !afull_q && !(&txfull_q)) begin
            txfull_d = txfull_q + CTR_WIDTH'(1);
        end
    end

    // Packet FSM; d-side values are the outputs for the next cycle.
    // In SEND, word_idx_q is the word on the bus; in STALL it is the
    // next word to send.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        seq_d      = seq_q;
        pkt_d      = pkt_q;
        tx_valid_d = 1'b0;
        tx_eof_d   = 1'b0;
        tx_data_d  = '0;
        last_word  = abort_w || (word_idx_q == len_q - LEN_WIDTH'(1));
`ifdef TGE_TX_SCHED_WDOG_EN
        stall_cnt_d = '0;
        abort_d     = abort_q;
        wdog_d      = wdog_q;
`endif

        unique case (state_q)
            IDLE: begin
`ifdef TGE_TX_SCHED_WDOG_EN
                abort_d = 1'b0;
`endif
                if (start) begin
                    len_d      = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
                    word_idx_d = '0;
                    state_d    = SEND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = {seq_q, 32'd0};
                    tx_eof_d   = (len_d == LEN_WIDTH'(1));
                end
            end
            SEND: begin
                if (last_word) begin
                    state_d = IDLE;
                    if (!abort_w) begin
                        pkt_d = pkt_q + CTR_WIDTH'(1);
                        seq_d = seq_q + 32'd1;
                    end
                end else begin
                    word_idx_d = word_idx_q + LEN_WIDTH'(1);
                    if (afull_q) begin
                        state_d = STALL;
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = {seq_q, 32'(word_idx_d)};
                        tx_eof_d   = (word_idx_d == len_q - LEN_WIDTH'(1));
                    end
                end
            end
            STALL: begin
                if (!afull_q) begin
                    state_d    = SEND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = {seq_q, 32'(word_idx_q)};
                    tx_eof_d   = last_word;
                end
`ifdef TGE_TX_SCHED_WDOG_EN
                if (afull_q && !abort_q) begin
                    stall_cnt_d = stall_cnt_q + 32'd1;
                    // Abort: the next word out becomes a lone end-of-frame
                    if (stall_cnt_d == 32'(WDOG_CYCLES)) begin
                        abort_d = 1'b1;
                        wdog_d  = 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q      <= IDLE;
            period_cnt_q <= '0;
            pending_q    <= 1'b0;
            afull_q      <= 1'b0;
            len_q        <= '0;
            word_idx_q   <= '0;
            seq_q        <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_eof_q     <= 1'b0;
            txfull_q     <= '0;
            pkt_q        <= '0;
            skip_q       <= '0;
`ifdef TGE_TX_SCHED_WDOG_EN
            stall_cnt_q  <= '0;
            abort_q      <= 1'b0;
            wdog_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            pending_q    <= pending_d;
            afull_q      <= tx_afull;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            seq_q        <= seq_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            tx_eof_q     <= tx_eof_d;
            txfull_q     <= txfull_d;
            pkt_q        <= pkt_d;
            skip_q       <= skip_d;
`ifdef TGE_TX_SCHED_WDOG_EN
            stall_cnt_q  <= stall_cnt_d;
            abort_q      <= abort_d;
            wdog_q       <= wdog_d;
`endif
        end
    end

    assign tx_valid        = tx_valid_q;
    assign tx_data         = tx_data_q;
    assign tx_end_of_frame = tx_eof_q;
    assign txfull_ctr      = txfull_q;
    assign pkt_ctr         = pkt_q;
    assign skip_ctr        = skip_q;

endmodule

// File: tb/tb_tge_tx_scheduler.sv
`timescale 1ns/1ps
// tb_tge_tx_scheduler: table-driven and scoreboard checks of the
// transmit scheduler (basic run, backpressure, overrun, reset, watchdog).

module tb_tge_tx_scheduler;

    logic        user_clk = 1'b0;
    logic        user_rst;
    logic        enable;
    logic [15:0] pkt_len;
    logic [31:0] period;
    logic        tx_afull;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic        tx_end_of_frame;
    logic [31:0] txfull_ctr;
    logic [31:0] pkt_ctr;
    logic [31:0] skip_ctr;
    logic        wdog_flag;

    tge_tx_scheduler #(
        .CTR_WIDTH  (32),
        .LEN_WIDTH  (16),
        .WDOG_CYCLES(16)
    ) dut (
        .user_clk       (user_clk),
        .user_rst       (user_rst),
        .enable         (enable),
        .pkt_len        (pkt_len),
        .period         (period),
        .tx_afull       (tx_afull),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_end_of_frame(tx_end_of_frame),
        .txfull_ctr     (txfull_ctr),
        .pkt_ctr        (pkt_ctr),
        .skip_ctr       (skip_ctr),
        .wdog_flag      (wdog_flag)
    );

    always #5 user_clk = ~user_clk;

    typedef struct packed {
        logic [63:0] data;
        logic        eof;
    } exp_t;

    typedef struct {
        logic        afull;
        logic        valid;
        logic        eof;
        logic [63:0] data;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic go();
        @(posedge user_clk);
        #1;
        cyc++;
    endtask

    task automatic settle();
        @(negedge user_clk);
    endtask

    task automatic do_reset();
        @(posedge user_clk);
        #1;
        user_rst = 1'b1;
        enable   = 1'b0;
        tx_afull = 1'b0;
        @(posedge user_clk);
        #1;
        @(posedge user_clk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] per, input logic [15:0] len);
        @(posedge user_clk);
        #1;
        user_rst = 1'b0;
        enable   = 1'b1;
        period   = per;
        pkt_len  = len;
        cyc      = 0;
    endtask

    task automatic push_word(input int s, input int w, input logic eof);
        exp_t e;
        e.data = {32'(s), 32'(w)};
        e.eof  = eof;
        sbq.push_back(e);
    endtask

    // Scoreboard monitor: every valid word must be the next expected one
    always @(negedge user_clk) begin
        if (mon_en && tx_valid) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_extra (cycle %0d): got word %0h, want none", cyc, tx_data);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_data", tx_data, mon_e.data);
                chk("sb_eof", 64'(tx_end_of_frame), 64'(mon_e.eof));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int first, last, nval, lows, w0;
        vec_t v;

        user_rst = 1'b1;
        enable   = 1'b0;
        tx_afull = 1'b0;
        pkt_len  = '0;
        period   = '0;

        // Reset state
        do_reset();
        settle();
        chk("rst_valid", 64'(tx_valid), 0);
        chk("rst_eof", 64'(tx_end_of_frame), 0);
        chk("rst_data", tx_data, 0);
        chk("rst_txfull", 64'(txfull_ctr), 0);
        chk("rst_pkt", 64'(pkt_ctr), 0);
        chk("rst_skip", 64'(skip_ctr), 0);
        chk("rst_wdog", 64'(wdog_flag), 0);

        // Basic run: period 10, 4 words; words in cycles 2-5, 12-15, 22-25
        for (int c = 0; c < 28; c++) begin
            v.afull = 1'b0;
            v.valid = (c % 10 >= 2) && (c % 10 <= 5);
            v.eof   = (c % 10 == 5);
            v.data  = {32'(c / 10), 32'((c % 10) - 2)};
            tbl.push_back(v);
        end
        start_run(32'd10, 16'd4);
        for (int i = 0; i < tbl.size(); i++) begin
            if (i > 0) go();
            tx_afull = tbl[i].afull;
            settle();
            chk("t1_valid", 64'(tx_valid), 64'(tbl[i].valid));
            chk("t1_eof", 64'(tx_end_of_frame), 64'(tbl[i].eof));
            if (tbl[i].valid) chk("t1_data", tx_data, tbl[i].data);
        end
        chk("t1_pkt_ctr", 64'(pkt_ctr), 3);
        chk("t1_skip_ctr", 64'(skip_ctr), 0);
        chk("t1_txfull_ctr", 64'(txfull_ctr), 0);

        // Mid-packet backpressure: afull high in cycles 4..8 (word 2 at 4)
        do_reset();
        for (int w = 0; w < 8; w++) push_word(0, w, w == 7);
        start_run(32'd1000, 16'd8);
        mon_en = 1'b1;
        first = -1;
        last  = -1;
        nval  = 0;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) go();
            tx_afull = (c >= 4) && (c <= 8);
            settle();
            if (tx_valid) begin
                if (first < 0) first = c;
                last = c;
                nval++;
            end
        end
        go();
        mon_en = 1'b0;
        settle();
        chk("t2_first_valid", 64'(first), 2);
        chk("t2_last_valid", 64'(last), 14);
        chk("t2_valid_lows", 64'((last - first + 1) - nval), 5);
        chk("t2_sb_empty", 64'(sbq.size()), 0);
        chk("t2_txfull_ctr", 64'(txfull_ctr), 1);
        chk("t2_pkt_ctr", 64'(pkt_ctr), 1);

        // Period shorter than packet: 20 ticks, 5 starts, 1 left pending
        do_reset();
        for (int s = 0; s < 5; s++)
            for (int w = 0; w < 8; w++) push_word(s, w, w == 7);
        start_run(32'd2, 16'd8);
        mon_en = 1'b1;
        lows = 0;
        w0   = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) go();
            settle();
            if (c >= 2 && !tx_valid) lows++;
            if (tx_valid && tx_data[31:0] == 32'd0) w0++;
        end
        go();
        mon_en = 1'b0;
        settle();
        chk("t3_gap_cycles", 64'(lows), 4);
        chk("t3_pkts_started", 64'(w0), 5);
        chk("t3_skip_ctr", 64'(skip_ctr), 64'(20 - (5 + 1)));
        chk("t3_pkt_ctr", 64'(pkt_ctr), 4);
        chk("t3_sb_left", 64'(sbq.size()), 6);
        sbq.delete();

        // Zero length: single-word packets at cycles 2, 7, 12
        do_reset();
        for (int s = 0; s < 3; s++) push_word(s, 0, 1'b1);
        start_run(32'd5, 16'd0);
        mon_en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) go();
            settle();
            chk("t4_valid", 64'(tx_valid), 64'(c == 2 || c == 7 || c == 12));
            chk("t4_eof", 64'(tx_end_of_frame), 64'(c == 2 || c == 7 || c == 12));
        end
        go();
        mon_en = 1'b0;
        settle();
        chk("t4_pkt_ctr", 64'(pkt_ctr), 3);
        chk("t4_sb_empty", 64'(sbq.size()), 0);

        // Afull hold-off in IDLE, then reset at word 3 of 8
        do_reset();
        start_run(32'd1000, 16'd8);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) go();
            tx_afull = (c == 0);
            if (c == 6) user_rst = 1'b1;
            if (c == 7) user_rst = 1'b0;
            settle();
            if (c == 1) chk("t5_txfull_pre", 64'(txfull_ctr), 1);
            if (c == 2) chk("t5_holdoff", 64'(tx_valid), 0);
            if (c == 3) chk("t5_word0", tx_data, 0);
            if (c == 6) chk("t5_word3", tx_data, 64'd3);
            if (c == 6) chk("t5_word3_valid", 64'(tx_valid), 1);
            if (c == 7) begin
                chk("t5_rst_valid", 64'(tx_valid), 0);
                chk("t5_rst_eof", 64'(tx_end_of_frame), 0);
                chk("t5_rst_txfull", 64'(txfull_ctr), 0);
                chk("t5_rst_pkt", 64'(pkt_ctr), 0);
                chk("t5_rst_skip", 64'(skip_ctr), 0);
            end
            if (c == 8) chk("t5_idle", 64'(tx_valid), 0);
            if (c == 9) begin
                chk("t5_restart_valid", 64'(tx_valid), 1);
                chk("t5_restart_data", tx_data, 0);
                chk("t5_restart_eof", 64'(tx_end_of_frame), 0);
            end
        end

        // Long stall: afull high for 20 cycles from word 2 (cycles 4..23)
        do_reset();
        for (int w = 0; w < 4; w++) push_word(0, w, 1'b0);
`ifdef TGE_TX_SCHED_WDOG_EN
        push_word(0, 4, 1'b1);
`else
        for (int w = 4; w < 8; w++) push_word(0, w, w == 7);
`endif
        start_run(32'd1000, 16'd8);
        mon_en = 1'b1;
        for (int c = 0; c < 32; c++) begin
            if (c > 0) go();
            tx_afull = (c >= 4) && (c <= 23);
            settle();
            if (c == 25) chk("t6_stalled", 64'(tx_valid), 0);
            if (c == 26) chk("t6_resume", 64'(tx_valid), 1);
`ifdef TGE_TX_SCHED_WDOG_EN
            if (c == 21) chk("t6_wdog_early", 64'(wdog_flag), 0);
            if (c == 22) chk("t6_wdog_set", 64'(wdog_flag), 1);
            if (c == 27) chk("t6_abort_idle", 64'(tx_valid), 0);
`else
            if (c == 22) chk("t6_wdog_off", 64'(wdog_flag), 0);
            if (c == 29) chk("t6_eof", 64'(tx_end_of_frame), 1);
`endif
        end
        go();
        mon_en = 1'b0;
        settle();
        chk("t6_sb_empty", 64'(sbq.size()), 0);
        chk("t6_txfull_ctr", 64'(txfull_ctr), 1);
`ifdef TGE_TX_SCHED_WDOG_EN
        chk("t6_pkt_ctr", 64'(pkt_ctr), 0);
        chk("t6_wdog_sticky", 64'(wdog_flag), 1);
`else
        chk("t6_pkt_ctr", 64'(pkt_ctr), 1);
        chk("t6_wdog_end", 64'(wdog_flag), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
